// File: rtl/vector_alu.sv
// Single-lane element ALU of the vector function unit: one element (or mask bit)
// per cycle from vs1/vs2/vs3, the scalar operands and the decoded opcode.
module vector_alu #(
  parameter int LANE_INDEX     = 0,
  parameter int LONGEST_LEN    = 64,
  parameter int SCALAR_REG_LEN = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                PREV_VSEW,
  input  logic [2:0]                CUR_VSEW,
  input  logic                      vm,
  input  logic [LONGEST_LEN-1:0]    vs1,
  input  logic [LONGEST_LEN-1:0]    vs2,
  input  logic [LONGEST_LEN-1:0]    vs3,
  input  logic                      mask,
  input  logic [SCALAR_REG_LEN-1:0] imm,
  input  logic [SCALAR_REG_LEN-1:0] rs,
  input  logic [2:0]                alu_signal,
  input  logic [1:0]                vec_operand_type,
  input  logic                      is_mask_operation,
  input  logic [5:0]                opcode,
  output logic [LONGEST_LEN-1:0]    result
);

  // The datapath below is written for 64-bit elements and scalars.
  if (LONGEST_LEN != 64 || SCALAR_REG_LEN != 64) begin : g_widthCheck
    $error("vector_alu lane %0d: only 64-bit LONGEST_LEN/SCALAR_REG_LEN supported", LANE_INDEX);
  end

  typedef enum logic [5:0] {
    OP_ADD   = 6'd0,  OP_SUB   = 6'd1,  OP_WADDU = 6'd2,  OP_WSUBU = 6'd3,
    OP_WADD  = 6'd4,  OP_WSUB  = 6'd5,  OP_ADC   = 6'd6,  OP_SBC   = 6'd7,
    OP_MADC  = 6'd8,  OP_MSBC  = 6'd9,  OP_MACC  = 6'd10, OP_NMSAC = 6'd11,
    OP_MADD  = 6'd12, OP_ZEXT2 = 6'd13, OP_ZEXT4 = 6'd14, OP_ZEXT8 = 6'd15,
    OP_SEXT2 = 6'd16, OP_SEXT4 = 6'd17, OP_SEXT8 = 6'd18
  } aluOp_e;

  function automatic logic [63:0] widthMask(input logic [1:0] sew);
    case (sew)
      2'd0:    widthMask = 64'h0000_0000_0000_00FF;
      2'd1:    widthMask = 64'h0000_0000_0000_FFFF;
      2'd2:    widthMask = 64'h0000_0000_FFFF_FFFF;
      default: widthMask = '1;
    endcase
  endfunction

  function automatic logic [63:0] signExt(input logic [63:0] x, input logic [1:0] sew);
    case (sew)
      2'd0:    signExt = {{56{x[7]}}, x[7:0]};
      2'd1:    signExt = {{48{x[15]}}, x[15:0]};
      2'd2:    signExt = {{32{x[31]}}, x[31:0]};
      default: signExt = x;
    endcase
  endfunction

  // Bit just above the destination width is the carry (or borrow) of a Wc-bit op.
  function automatic logic carryOut(input logic [64:0] s, input logic [1:0] sew);
    case (sew)
      2'd0:    carryOut = s[8];
      2'd1:    carryOut = s[16];
      2'd2:    carryOut = s[32];
      default: carryOut = s[64];
    endcase
  endfunction

  logic        sewValid;
  logic [63:0] pMask, cMask;
  logic [63:0] opA, a, b, d, aS, bS, aC, bC;
  logic        cin, isCarryOp;
  logic [64:0] carrySum, borrowDiff;
  logic [63:0] value, shaped;
  logic [63:0] result_d, result_q;

  always_comb begin
    sewValid = ~PREV_VSEW[2] & ~CUR_VSEW[2];
    pMask    = widthMask(PREV_VSEW[1:0]);
    cMask    = widthMask(CUR_VSEW[1:0]);

    case (vec_operand_type)
      2'b01:   opA = rs;
      2'b10:   opA = imm;
      default: opA = vs1;
    endcase

    a  = opA & pMask;
    b  = vs2 & pMask;
    d  = vs3 & pMask;
    aS = signExt(a, PREV_VSEW[1:0]);
    bS = signExt(b, PREV_VSEW[1:0]);
    aC = a & cMask;
    bC = b & cMask;

    // Carry-in for MADC/MSBC only counts when the op is explicitly masked.
    cin        = ~vm & mask;
    carrySum   = {1'b0, bC} + {1'b0, aC} + {64'b0, cin};
    borrowDiff = {1'b0, bC} - {1'b0, aC} - {64'b0, cin};

    isCarryOp = (opcode == OP_ADC) || (opcode == OP_SBC) ||
                (opcode == OP_MADC) || (opcode == OP_MSBC);

    value = '0;
    case (aluOp_e'(opcode))
      OP_ADD, OP_WADDU:              value = b + a;
      OP_SUB, OP_WSUBU:              value = b - a;
      OP_WADD:                       value = bS + aS;
      OP_WSUB:                       value = bS - aS;
      OP_ADC:                        value = b + a + {63'b0, mask};
      OP_SBC:                        value = b - a - {63'b0, mask};
      OP_MADC:                       value = {63'b0, carryOut(carrySum, CUR_VSEW[1:0])};
      OP_MSBC:                       value = {63'b0, carryOut(borrowDiff, CUR_VSEW[1:0])};
      OP_MACC:                       value = d + a * b;
      OP_NMSAC:                      value = d - a * b;
      OP_MADD:                       value = a * d + b;
      OP_ZEXT2, OP_ZEXT4, OP_ZEXT8:  value = b;
      OP_SEXT2, OP_SEXT4, OP_SEXT8:  value = bS;
      default:                       value = '0;
    endcase

    shaped = is_mask_operation ? {63'b0, value[0]} : (value & cMask);

    // Inactive elements keep the destination contents (vs3) untouched.
    result_d = '0;
    if (sewValid) begin
      case (alu_signal)
        3'd1:    result_d = (!vm && !mask && !isCarryOp) ? vs3 : shaped;
        3'd2:    result_d = vs3;
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) result_q <= '0;
    else     result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_vector_alu.sv
// Self-checking bench for vector_alu: directed cases from the element rules,
// then randomized operations checked against an arithmetic reference model.
module tb_vector_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  PREV_VSEW, CUR_VSEW;
  logic        vm, mask;
  logic [63:0] vs1, vs2, vs3, imm, rs;
  logic [2:0]  alu_signal;
  logic [1:0]  vec_operand_type;
  logic        is_mask_operation;
  logic [5:0]  opcode;
  logic [63:0] result;

  int testsRun    = 0;
  int testsFailed = 0;

  vector_alu #(.LANE_INDEX(0), .LONGEST_LEN(64), .SCALAR_REG_LEN(64)) dut (
    .clk(clk), .rst(rst), .PREV_VSEW(PREV_VSEW), .CUR_VSEW(CUR_VSEW), .vm(vm),
    .vs1(vs1), .vs2(vs2), .vs3(vs3), .mask(mask), .imm(imm), .rs(rs),
    .alu_signal(alu_signal), .vec_operand_type(vec_operand_type),
    .is_mask_operation(is_mask_operation), .opcode(opcode), .result(result)
  );

  always #5 clk = ~clk;

  // Element rules evaluated with wide plain arithmetic and integer widths.
  function automatic logic [63:0] refModel(
    input logic [2:0] pv, input logic [2:0] cv, input logic vmI, input logic maskI,
    input logic [63:0] v1, input logic [63:0] v2, input logic [63:0] v3,
    input logic [63:0] immI, input logic [63:0] rsI, input logic [2:0] sig,
    input logic [1:0] ot, input logic isMask, input logic [5:0] op);
    int wp, wc;
    logic [127:0] mp, mc, src, a, b, d, sa, sb, val, cin;
    if (pv > 3 || cv > 3) return 64'd0;
    if (sig == 3'd2) return v3;
    if (sig != 3'd1) return 64'd0;
    wp = 8 << pv;
    wc = 8 << cv;
    mp = (128'd1 << wp) - 128'd1;
    mc = (128'd1 << wc) - 128'd1;
    src = (ot == 2'b01) ? {64'd0, rsI} : (ot == 2'b10) ? {64'd0, immI} : {64'd0, v1};
    a = src & mp;
    b = {64'd0, v2} & mp;
    d = {64'd0, v3} & mp;
    sa = a[wp-1] ? (a | ~mp) : a;
    sb = b[wp-1] ? (b | ~mp) : b;
    if (!vmI && !maskI && !(op >= 6'd6 && op <= 6'd9)) return v3;
    cin = (vmI ? 128'd0 : {127'd0, maskI});
    case (op)
      6'd0, 6'd2:   val = b + a;
      6'd1, 6'd3:   val = b - a;
      6'd4:         val = sb + sa;
      6'd5:         val = sb - sa;
      6'd6:         val = b + a + {127'd0, maskI};
      6'd7:         val = b - a - {127'd0, maskI};
      6'd8:         val = (((b & mc) + (a & mc) + cin) >> wc) & 128'd1;
      6'd9:         val = ((b & mc) < ((a & mc) + cin)) ? 128'd1 : 128'd0;
      6'd10:        val = d + a * b;
      6'd11:        val = d - a * b;
      6'd12:        val = a * d + b;
      6'd13, 6'd14, 6'd15: val = b;
      6'd16, 6'd17, 6'd18: val = sb;
      default:      return 64'd0;
    endcase
    if (isMask) return {63'd0, val[0]};
    return val[63:0] & mc[63:0];
  endfunction

  task automatic applyStimulus(
    input logic [2:0] pv, input logic [2:0] cv, input logic vmI, input logic maskI,
    input logic [63:0] v1, input logic [63:0] v2, input logic [63:0] v3,
    input logic [63:0] immI, input logic [63:0] rsI, input logic [2:0] sig,
    input logic [1:0] ot, input logic isMask, input logic [5:0] op);
    PREV_VSEW = pv; CUR_VSEW = cv; vm = vmI; mask = maskI;
    vs1 = v1; vs2 = v2; vs3 = v3; imm = immI; rs = rsI;
    alu_signal = sig; vec_operand_type = ot; is_mask_operation = isMask; opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] expected);
    testsRun++;
    assert (result === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, result, expected);
    end
  endtask

  initial begin
    logic [63:0] expV;
    logic [2:0]  rp, rc, rsig;
    logic [5:0]  rop;

    rst = 1'b1;
    PREV_VSEW = '0; CUR_VSEW = '0; vm = 1'b1; mask = 1'b0;
    vs1 = '0; vs2 = '0; vs3 = '0; imm = '0; rs = '0;
    alu_signal = '0; vec_operand_type = '0; is_mask_operation = 1'b0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetState", 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed element cases
    applyStimulus(3'd0, 3'd0, 1, 0, 64'h20, 64'hF0, 0, 0, 0, 3'd1, 2'b00, 0, 6'd0);
    checkOutput("add8", 64'h10);
    applyStimulus(3'd0, 3'd0, 1, 0, 0, 64'h10, 0, 0, 64'h30, 3'd1, 2'b01, 0, 6'd1);
    checkOutput("subVx8", 64'hE0);
    applyStimulus(3'd0, 3'd1, 1, 0, 64'h01, 64'h80, 0, 0, 0, 3'd1, 2'b00, 0, 6'd4);
    checkOutput("wadd8to16", 64'hFF81);
    applyStimulus(3'd0, 3'd1, 1, 0, 64'h01, 64'h80, 0, 0, 0, 3'd1, 2'b00, 0, 6'd2);
    checkOutput("waddu8to16", 64'h0081);
    applyStimulus(3'd2, 3'd2, 0, 0, 0, 64'hFFFF_FFFF, 0, 64'd1, 0, 3'd1, 2'b10, 1, 6'd8);
    checkOutput("madcCarry", 64'd1);
    applyStimulus(3'd2, 3'd2, 0, 1, 0, 64'hFFFF_FFFF, 0, 64'd0, 0, 3'd1, 2'b10, 1, 6'd8);
    checkOutput("madcCin", 64'd1);
    applyStimulus(3'd2, 3'd2, 0, 0, 0, 64'd1, 0, 64'd1, 0, 3'd1, 2'b10, 1, 6'd8);
    checkOutput("madcNoCarry", 64'd0);
    applyStimulus(3'd1, 3'd1, 0, 0, 64'd2, 64'd1, 64'h1234, 0, 0, 3'd1, 2'b00, 0, 6'd0);
    checkOutput("maskedOff", 64'h1234);
    applyStimulus(3'd1, 3'd1, 0, 1, 64'd2, 64'd1, 64'h1234, 0, 0, 3'd1, 2'b00, 0, 6'd0);
    checkOutput("maskedOn", 64'h0003);
    applyStimulus(3'd1, 3'd1, 1, 0, 64'd3, 64'd4, 64'd5, 0, 0, 3'd1, 2'b00, 0, 6'd10);
    checkOutput("macc", 64'd17);
    applyStimulus(3'd0, 3'd2, 1, 0, 0, 64'h80, 0, 0, 0, 3'd1, 2'b00, 0, 6'd17);
    checkOutput("sext4", 64'hFFFF_FF80);
    applyStimulus(3'd0, 3'd3, 1, 0, 0, 64'h80, 0, 0, 0, 3'd1, 2'b00, 0, 6'd15);
    checkOutput("zext8", 64'h80);
    applyStimulus(3'd1, 3'd1, 1, 0, 0, 0, 64'hABCD, 0, 0, 3'd2, 2'b00, 0, 6'd0);
    checkOutput("passVs3", 64'hABCD);
    applyStimulus(3'd1, 3'd1, 1, 0, 64'd1, 64'd1, 64'hABCD, 0, 0, 3'd1, 2'b00, 0, 6'd63);
    checkOutput("badOpcode", 64'd0);
    applyStimulus(3'd5, 3'd1, 1, 0, 64'd1, 64'd1, 64'hABCD, 0, 0, 3'd1, 2'b00, 0, 6'd0);
    checkOutput("badVsew", 64'd0);
    applyStimulus(3'd3, 3'd3, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0, 0, 0, 3'd1, 2'b00, 0, 6'd10);
    checkOutput("mul64Trunc", 64'hFFFF_FFFF_FFFF_FFFD);

    // Asynchronous reset in the middle of operation
    applyStimulus(3'd0, 3'd0, 1, 0, 64'd0, 64'h55, 0, 0, 0, 3'd1, 2'b00, 0, 6'd0);
    checkOutput("preReset", 64'h55);
    rst = 1'b1;
    #1;
    checkOutput("asyncClear", 64'd0);
    @(posedge clk);
    #1;
    checkOutput("resetHold", 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("releaseNoEdge", 64'd0);
    @(posedge clk);
    #1;
    checkOutput("firstCapture", 64'h55);

    // Randomized operations against the reference model
    for (int i = 0; i < 300; i++) begin
      rp   = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      rc   = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      rsig = ($urandom_range(0, 4) != 0) ? 3'd1 : 3'($urandom_range(0, 7));
      rop  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(19, 63)) : 6'($urandom_range(0, 18));
      applyStimulus(rp, rc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, rsig,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rop);
      expV = refModel(PREV_VSEW, CUR_VSEW, vm, mask, vs1, vs2, vs3, imm, rs,
                      alu_signal, vec_operand_type, is_mask_operation, opcode);
      checkOutput($sformatf("rand%0d_op%0d", i, opcode), expV);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
